// File: rtl/registro_reg_exe.sv
// registro_reg_exe: Reg/Exe pipeline register with load-use stall, flush, hold and stall counter
module registro_reg_exe #(
  parameter int DATA_W = 16,
  parameter int LOAD_STALL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        Ra_F_Reg,
  input  logic [3:0]        Rb_F_Reg,
  input  logic [3:0]        Robj_F_Reg,
  input  logic              RE_A_F_Reg,
  input  logic              RE_B_F_Reg,
  input  logic              WE_F_Reg,
  input  logic              mem_WE_F_Reg,
  input  logic              mem_RE_F_Reg,
  input  logic              valid_F_Reg,
  input  logic [3:0]        aluop_F_Reg,
  input  logic [DATA_W-1:0] A_F_Reg,
  input  logic [DATA_W-1:0] B_F_Reg,
  input  logic [DATA_W-1:0] imm_F_Reg,
  input  logic              flush,
  input  logic              hold,
  output logic [3:0]        Ra_Reg_Exe,
  output logic [3:0]        Rb_Reg_Exe,
  output logic [3:0]        Robj_Reg_Exe,
  output logic              RE_A_Reg_Exe,
  output logic              RE_B_Reg_Exe,
  output logic              WE_Reg_Exe,
  output logic              mem_WE_Reg_Exe,
  output logic              mem_RE_Reg_Exe,
  output logic              valid_Reg_Exe,
  output logic [3:0]        aluop_Reg_Exe,
  output logic [DATA_W-1:0] A_Reg_Exe,
  output logic [DATA_W-1:0] B_Reg_Exe,
  output logic [DATA_W-1:0] imm_Reg_Exe,
  output logic              stall_F,
  output logic [15:0]       stall_cycles
);
  typedef struct packed {
    logic [3:0]        ra, rb, robj;
    logic              re_a, re_b, we, mem_we, mem_re, valid;
    logic [3:0]        aluop;
    logic [DATA_W-1:0] a, b, imm;
  } pipe_t;
  typedef enum logic {RUN, STALL} state_t;
  pipe_t pipe_q, pipe_d, pipe_in;
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic haz;
  assign pipe_in = {Ra_F_Reg, Rb_F_Reg, Robj_F_Reg, RE_A_F_Reg, RE_B_F_Reg, WE_F_Reg,
                    mem_WE_F_Reg, mem_RE_F_Reg, valid_F_Reg, aluop_F_Reg, A_F_Reg, B_F_Reg, imm_F_Reg};
  assign {Ra_Reg_Exe, Rb_Reg_Exe, Robj_Reg_Exe, RE_A_Reg_Exe, RE_B_Reg_Exe, WE_Reg_Exe,
          mem_WE_Reg_Exe, mem_RE_Reg_Exe, valid_Reg_Exe, aluop_Reg_Exe, A_Reg_Exe, B_Reg_Exe,
          imm_Reg_Exe} = pipe_q;
  assign stall_cycles = stall_cycles_q;
  // store data through Rb is forwarded from Mem, so only ALU operand reads count
  assign haz = pipe_q.mem_re & pipe_q.we & pipe_q.valid & valid_F_Reg &
               ((RE_A_F_Reg & (Ra_F_Reg == pipe_q.robj)) | (RE_B_F_Reg & (Rb_F_Reg == pipe_q.robj)));
  // next-state, stall request and stall counter; flush beats hold beats stall
  always_comb begin
    pipe_d = pipe_q;
    state_d = state_q;
    cnt_d = cnt_q;
    stall_F = reset ? 1'b0 : (state_q == STALL) | haz;
    stall_cycles_d = (stall_F && !flush && stall_cycles_q != 16'hFFFF) ? stall_cycles_q + 16'd1 : stall_cycles_q;
    if (flush) begin
      pipe_d = '0;
      state_d = RUN;
      cnt_d = '0;
    end else if (hold) begin
      pipe_d = pipe_q;
    end else if (state_q == STALL) begin
      pipe_d = '0;
      cnt_d = cnt_q - 3'd1;
      state_d = (cnt_q == 3'd1) ? RUN : STALL;
    end else if (haz) begin
      pipe_d = '0;
      state_d = (LOAD_STALL > 1) ? STALL : RUN;
      cnt_d = (LOAD_STALL > 1) ? 3'(LOAD_STALL - 1) : 3'd0;
    end else begin
      pipe_d = pipe_in;
    end
  end
  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_q <= '0;
      state_q <= RUN;
      cnt_q <= '0;
      stall_cycles_q <= '0;
    end else begin
      pipe_q <= pipe_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end
endmodule

// File: tb/tb_registro_reg_exe.sv
// tb_registro_reg_exe: random and directed check of two registro_reg_exe instances (LOAD_STALL 1 and 3)
module tb_registro_reg_exe;
  typedef struct packed {
    logic [3:0]  ra, rb, robj;
    logic        re_a, re_b, we, mwe, mre, valid;
    logic [3:0]  aluop;
    logic [15:0] a, b, imm;
  } rec_t;
  logic clk, reset, hold, flush, chk;
  rec_t in;
  rec_t dq [2];
  logic s [2];
  logic [15:0] sc [2];
  rec_t m_exe [2];
  int m_rem [2];
  int m_sc [2];
  int n_chk, n_fail;
  initial clk = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [3:0] ra_o, rb_o, robj_o, aluop_o;
    logic re_a_o, re_b_o, we_o, mwe_o, mre_o, valid_o;
    logic [15:0] a_o, b_o, imm_o;
    registro_reg_exe #(.DATA_W(16), .LOAD_STALL(g == 0 ? 1 : 3)) dut (
      .clk(clk), .reset(reset),
      .Ra_F_Reg(in.ra), .Rb_F_Reg(in.rb), .Robj_F_Reg(in.robj),
      .RE_A_F_Reg(in.re_a), .RE_B_F_Reg(in.re_b), .WE_F_Reg(in.we),
      .mem_WE_F_Reg(in.mwe), .mem_RE_F_Reg(in.mre), .valid_F_Reg(in.valid),
      .aluop_F_Reg(in.aluop), .A_F_Reg(in.a), .B_F_Reg(in.b), .imm_F_Reg(in.imm),
      .flush(flush), .hold(hold),
      .Ra_Reg_Exe(ra_o), .Rb_Reg_Exe(rb_o), .Robj_Reg_Exe(robj_o),
      .RE_A_Reg_Exe(re_a_o), .RE_B_Reg_Exe(re_b_o), .WE_Reg_Exe(we_o),
      .mem_WE_Reg_Exe(mwe_o), .mem_RE_Reg_Exe(mre_o), .valid_Reg_Exe(valid_o),
      .aluop_Reg_Exe(aluop_o), .A_Reg_Exe(a_o), .B_Reg_Exe(b_o), .imm_Reg_Exe(imm_o),
      .stall_F(s[g]), .stall_cycles(sc[g])
    );
    assign dq[g] = {ra_o, rb_o, robj_o, re_a_o, re_b_o, we_o, mwe_o, mre_o, valid_o, aluop_o, a_o, b_o, imm_o};
  end
  function automatic int nof(int k);
    return k == 0 ? 1 : 3;
  endfunction
  function automatic logic mhaz(int k);
    rec_t e = m_exe[k];
    return e.mre && e.we && e.valid && in.valid &&
           ((in.re_a && in.ra == e.robj) || (in.re_b && in.rb == e.robj));
  endfunction
  function automatic logic mstall(int k);
    return !reset && (m_rem[k] > 0 || mhaz(k));
  endfunction
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic st, hz;
      st = mstall(k);
      hz = mhaz(k);
      if (reset) begin
        m_exe[k] = '0; m_rem[k] = 0; m_sc[k] = 0;
      end else begin
        if (st && !flush && m_sc[k] < 65535) m_sc[k]++;
        if (flush) begin
          m_exe[k] = '0; m_rem[k] = 0;
        end else if (hold) begin
        end else if (m_rem[k] > 0) begin
          m_exe[k] = '0; m_rem[k]--;
        end else if (hz) begin
          m_exe[k] = '0; m_rem[k] = nof(k) - 1;
        end else m_exe[k] = in;
      end
    end
  end
  always @(negedge clk) if (chk) begin
    for (int k = 0; k < 2; k++) begin
      n_chk += 3;
      if (dq[k] !== m_exe[k]) begin
        n_fail++; $display("FAIL exe dut%0d got %h want %h", k, dq[k], m_exe[k]);
      end
      if (s[k] !== mstall(k)) begin
        n_fail++; $display("FAIL stall_F dut%0d got %b want %b", k, s[k], mstall(k));
      end
      if (sc[k] !== 16'(m_sc[k])) begin
        n_fail++; $display("FAIL stall_cycles dut%0d got %0d want %0d", k, sc[k], m_sc[k]);
      end
    end
  end
  task automatic lit(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++; $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  rec_t add1, ld4, add_r4, st_r4;
  int n0, n1, f0, f1;
  initial begin
    n_chk = 0; n_fail = 0; chk = 0;
    in = '0; hold = 0; flush = 0; reset = 1;
    add1 = '0; add1.valid = 1; add1.we = 1; add1.robj = 1; add1.ra = 2; add1.rb = 3;
    add1.re_a = 1; add1.re_b = 1; add1.a = 16'h0005;
    ld4 = '0; ld4.valid = 1; ld4.we = 1; ld4.mre = 1; ld4.robj = 4;
    add_r4 = '0; add_r4.valid = 1; add_r4.we = 1; add_r4.robj = 5; add_r4.ra = 4; add_r4.rb = 6;
    add_r4.re_a = 1; add_r4.re_b = 1; add_r4.a = 16'h1234;
    st_r4 = '0; st_r4.valid = 1; st_r4.mwe = 1; st_r4.rb = 4; st_r4.ra = 7; st_r4.re_a = 1;
    repeat (2) tick();
    chk = 1;
    lit("reset_exe", 32'(dq[1]), 0);
    lit("reset_sc", 32'(sc[0]), 0);
    reset = 0; in = add1;
    tick();
    for (int k = 0; k < 2; k++) begin
      lit("add_robj", 32'(dq[k].robj), 1);
      lit("add_we", 32'(dq[k].we), 1);
      lit("add_a", 32'(dq[k].a), 32'h5);
      lit("add_stall", 32'(s[k]), 0);
    end
    in = ld4; tick();
    in = add_r4; n0 = 0; n1 = 0; f0 = -1; f1 = -1;
    for (int i = 0; i < 6; i++) begin
      #2; n0 += 32'(s[0]); n1 += 32'(s[1]);
      tick();
      if (dq[0].robj == 5 && f0 < 0) f0 = i;
      if (dq[1].robj == 5 && f1 < 0) f1 = i;
    end
    lit("lu1_stalls", 32'(n0), 1);
    lit("lu3_stalls", 32'(n1), 3);
    lit("lu1_enter", 32'(f0), 1);
    lit("lu3_enter", 32'(f1), 3);
    lit("lu1_sc", 32'(sc[0]), 1);
    lit("lu3_sc", 32'(sc[1]), 3);
    lit("lu3_stall_after", 32'(s[1]), 0);
    in = ld4; tick();
    in = st_r4; #1;
    lit("st_stall0", 32'(s[0]), 0);
    lit("st_stall1", 32'(s[1]), 0);
    tick();
    lit("st_enter0", 32'(dq[0].mwe), 1);
    lit("st_enter1", 32'(dq[1].mwe), 1);
    in = ld4; tick();
    in = add_r4; n0 = 0; n1 = 0;
    #2; n0 += 32'(s[0]); n1 += 32'(s[1]); tick();
    hold = 1;
    repeat (2) begin #2; n0 += 32'(s[0]); n1 += 32'(s[1]); tick(); end
    lit("hold_frozen", 32'(dq[1]), 0);
    hold = 0;
    repeat (5) begin #2; n0 += 32'(s[0]); n1 += 32'(s[1]); tick(); end
    lit("hold_stalls3", 32'(n1), 5);
    lit("hold_stalls1", 32'(n0), 1);
    in = ld4; tick();
    in = add_r4; flush = 1; hold = 1; #1;
    lit("flush_haz", 32'(s[1]), 1);
    tick();
    flush = 0; hold = 0; #1;
    lit("flush_bubble", 32'(dq[1]), 0);
    lit("flush_stall", 32'(s[1]), 0);
    repeat (3000) begin
      in.ra = 4'($urandom_range(0, 3)); in.rb = 4'($urandom_range(0, 3));
      in.robj = 4'($urandom_range(0, 3));
      in.re_a = 1'($urandom); in.re_b = 1'($urandom); in.we = ($urandom_range(0, 3) != 0);
      in.mwe = 1'($urandom); in.mre = 1'($urandom); in.valid = ($urandom_range(0, 6) != 0);
      in.aluop = 4'($urandom); in.a = 16'($urandom); in.b = 16'($urandom); in.imm = 16'($urandom);
      hold = ($urandom_range(0, 9) == 0); flush = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 0; hold = 0; flush = 0; in = '0;
    repeat (4) tick();
    in = ld4; tick();
    in = add_r4; hold = 1;
    repeat (65600) tick();
    lit("sat0", 32'(sc[0]), 32'hFFFF);
    lit("sat1", 32'(sc[1]), 32'hFFFF);
    hold = 0; tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/registro_reg_exe.md
# registro_reg_exe

Pipeline register between the register-read (Reg) stage and the execute (Exe) stage of the filter processor, plus load-use hazard detection. It latches the decoded instruction and operands that the forwarding unit and ALU consume as `*_Reg_Exe`. When a load in Exe feeds an ALU operand of the instruction in Reg, it stalls fetch and decode and inserts bubbles. It also handles branch flush, memory-wait hold and a saturating stall-cycle counter.

## Interface
Parameters:
- DATA_W, 16, operand/immediate width
- LOAD_STALL, 1, bubbles inserted per load-use hazard (1..7)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- Ra_F_Reg, Rb_F_Reg, Robj_F_Reg  in  4 each  source/destination register indices from decode
- RE_A_F_Reg, RE_B_F_Reg  in  1 each  operand A/B read by ALU
- WE_F_Reg, mem_WE_F_Reg, mem_RE_F_Reg, valid_F_Reg  in  1 each  regfile write, store, load, instruction valid
- aluop_F_Reg  in  4  ALU operation
- A_F_Reg, B_F_Reg, imm_F_Reg  in  DATA_W each  register-file read data and immediate
- flush  in  1  taken branch from Exe; kill the instruction entering Exe
- hold  in  1  memory wait; freeze this register
- Ra_Reg_Exe, Rb_Reg_Exe, Robj_Reg_Exe  out  4 each  registered copies
- RE_A_Reg_Exe, RE_B_Reg_Exe, WE_Reg_Exe, mem_WE_Reg_Exe, mem_RE_Reg_Exe, valid_Reg_Exe  out  1 each
- aluop_Reg_Exe  out  4
- A_Reg_Exe, B_Reg_Exe, imm_Reg_Exe  out  DATA_W each
- stall_F  out  1  combinational; hold PC and F/Reg register
- stall_cycles  out  16  saturating count of cycles with stall_F=1

## Operation
- Bubble: every `*_Reg_Exe` output is 0 (indices, enables, valid, aluop, data).
- Hazard (combinational): `haz = mem_RE_Reg_Exe & WE_Reg_Exe & valid_Reg_Exe & valid_F_Reg & ((RE_A_F_Reg & Ra_F_Reg==Robj_Reg_Exe) | (RE_B_F_Reg & Rb_F_Reg==Robj_Reg_Exe))`.
- The store-data path (`mem_WE_F_Reg` with Rb) does not count as a hazard. Memory-stage forwarding covers it.
- Register index 0 gets no special treatment.
- FSM states: RUN and STALL, plus a 3-bit counter `cnt`.
  - In RUN, `stall_F = haz`.
  - In STALL, `stall_F = 1`.
- Edge actions, highest priority first:
  1. reset: all outputs take the bubble value; state=RUN; cnt=0; stall_cycles=0.
  2. flush: all outputs take the bubble value; state=RUN; cnt=0. Flush overrides hold and any pending stall.
  3. hold: all outputs, state and cnt keep their values.
  4. RUN with haz:
     - Load a bubble.
     - If LOAD_STALL>1, go to STALL with cnt=LOAD_STALL-1.
     - Otherwise stay in RUN.
  5. STALL:
     - Load a bubble.
     - Decrement cnt.
     - When cnt==1 before the edge, go to RUN.
  6. RUN without haz: load all `*_F_Reg` inputs into the `*_Reg_Exe` outputs.
- stall_cycles increments on each edge where stall_F=1, reset=0 and flush=0, including edges where hold=1. It saturates at 0xFFFF.
- stall_F is forced to 0 while reset=1.
- After a stall, the hazard does not re-fire, because Exe then holds a bubble.

## Timing
- Latency: 1 cycle from the F_Reg inputs to the Reg_Exe outputs.
- stall_F is valid in the same cycle as the inputs that cause it.
- The upstream stage samples stall_F before the same edge.
- With LOAD_STALL=N, one hazard gives exactly N consecutive stall_F cycles, assuming no hold and no flush.
- The stalled instruction enters Exe on the edge after the last stall cycle. The load is then in WB, so the forwarding unit selects the WB path.
- hold in the middle of a stall extends the stall. cnt is frozen for as long as hold=1.
- flush and haz in the same cycle: flush wins, and there is no STALL entry.
- Reset asserted mid-stall: the next edge gives state=RUN, bubble outputs and stall_F=0.

## Test plan
- Reset, then `ADD R1,R2,R3` presented (valid=1, WE=1, Robj=1, A=0x0005) -> next edge: Robj_Reg_Exe=1, WE_Reg_Exe=1, A_Reg_Exe=0x0005, stall_F=0.
- `LD R4` in Exe (mem_RE=1, WE=1, Robj=4), with `ADD R5,R4,R6` in Reg (RE_A=1, Ra=4), LOAD_STALL=1 -> stall_F=1 for one cycle, then one bubble in Exe, then ADD enters Exe with stall_F=0 and stall_cycles=1.
- Same as above with LOAD_STALL=3 -> stall_F=1 for 3 cycles, 3 bubbles, stall_cycles=3.
- Load-use where the consumer is a store using R4 only as data (mem_WE=1, RE_B=0) -> stall_F=0 and no bubble.
- LOAD_STALL=3 stall with hold=1 for 2 cycles in the middle -> stall_F=1 for 5 cycles and outputs frozen during hold.
- flush asserted in a cycle with both haz=1 and hold=1 -> next edge gives bubble outputs, state RUN, stall_F=0.
